// File: rtl/seg7_enc_pack.sv
// Purpose: encode 7-segment patterns to hex codes, pack two codes per byte.
// Latency: byte_valid rises the cycle after the second code is accepted.
// Backpressure: seg_ready low while a packed byte waits for byte_ready.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   seg_in/seg_valid/...  - segment pattern input handshake (a = MSB .. g = LSB)
//   byte_out/byte_valid/  - packed byte output handshake towards UART TX
//   byte_ready
//   err_pulse, err_code   - one-cycle error strobe; 01 invalid pattern, 10 timeout
//   busy                  - state is not IDLE
//   err_cnt               - saturating error counter, only with SEG7_ENC_ERR_CNT_EN
//
// Parameters: HI_FIRST (first code in high nibble), TIMEOUT_CYC (0 = no timeout).
// Optional macro: SEG7_ENC_ERR_CNT_EN adds the err_cnt output.
module seg7_enc_pack #(
    parameter bit          HI_FIRST    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic       busy
`ifdef SEG7_ENC_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    // Last counter value before the timeout fires; unused when disabled.
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYC - 1) : 16'd0;

    state_t      r_state;
    logic [3:0]  r_code;
    logic [15:0] r_cnt;
    logic [7:0]  r_byte;
    logic        r_byte_vld;
    logic        r_err_pulse;
    logic [1:0]  r_err_code;

    logic [3:0]  w_code;
    logic        w_code_ok;
    logic        w_accept;
    logic        w_timeout;
    logic        w_err_evt;

    // Pattern -> code lookup; anything not in the table is invalid.
    always_comb begin
        w_code    = 4'h0;
        w_code_ok = 1'b1;
        case (seg_in)
            7'b1111110: w_code = 4'h0;
            7'b0110000: w_code = 4'h1;
            7'b1101101: w_code = 4'h2;
            7'b1111001: w_code = 4'h3;
            7'b0110011: w_code = 4'h4;
            7'b1011011: w_code = 4'h5;
            7'b1011111: w_code = 4'h6;
            7'b1110010: w_code = 4'h7;
            7'b1111111: w_code = 4'h8;
            7'b1111011: w_code = 4'h9;
            7'b1001110: w_code = 4'hA;
            7'b1110111: w_code = 4'hB;
            7'b1100111: w_code = 4'hC;
            7'b0011111: w_code = 4'hD;
            7'b1001111: w_code = 4'hE;
            7'b0111101: w_code = 4'hF;
            default:    w_code_ok = 1'b0;
        endcase
    end

    assign seg_ready = (r_state != ST_FULL);
    assign w_accept  = seg_valid && seg_ready;
    // An accept in the same cycle always takes priority over the timeout.
    assign w_timeout = TO_EN && (r_state == ST_HALF) && !w_accept && (r_cnt == TO_LAST);
    // Accept implies IDLE or HALF, so a bad pattern here is always an error.
    assign w_err_evt = (w_accept && !w_code_ok) || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_code      <= 4'h0;
            r_cnt       <= 16'd0;
            r_byte      <= 8'h00;
            r_byte_vld  <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_err_pulse <= w_err_evt;
            if (w_err_evt) begin
                r_err_code <= w_timeout ? 2'b10 : 2'b01;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_code_ok) begin
                        r_code  <= w_code;
                        r_cnt   <= 16'd0;
                        r_state <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    // Keeps counting through rejected patterns.
                    r_cnt <= r_cnt + 16'd1;
                    if (w_accept && w_code_ok) begin
                        r_byte     <= HI_FIRST ? {r_code, w_code} : {w_code, r_code};
                        r_byte_vld <= 1'b1;
                        r_state    <= ST_FULL;
                    end else if (w_timeout) begin
                        r_code  <= 4'h0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (byte_ready) begin
                        r_byte_vld <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEG7_ENC_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Counted on the same edge that raises err_pulse; sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign byte_out   = r_byte;
    assign byte_valid = r_byte_vld;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seg7_enc_pack.sv
// Directed bench for seg7_enc_pack: main instance HI_FIRST=1, TIMEOUT_CYC=4;
// second instance HI_FIRST=0 with the timeout disabled.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_enc_pack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;

    logic [6:0] seg_in2;
    logic       seg_valid2;
    logic       seg_ready2;
    logic [7:0] byte_out2;
    logic       byte_valid2;
    logic       byte_ready2;
    logic       err_pulse2;
    logic [1:0] err_code2;
    logic       busy2;

`ifdef SEG7_ENC_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic [7:0] err_cnt2;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Patterns for codes 0..F, written out from the code table.
    logic [6:0] pat [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
        7'b1111111, 7'b1111011, 7'b1001110, 7'b1110111,
        7'b1100111, 7'b0011111, 7'b1001111, 7'b0111101
    };

    always #5 clk = ~clk;

    seg7_enc_pack #(.HI_FIRST(1'b1), .TIMEOUT_CYC(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .busy       (busy)
`ifdef SEG7_ENC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    seg7_enc_pack #(.HI_FIRST(1'b0), .TIMEOUT_CYC(0)) u_dut_lo (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in2),
        .seg_valid  (seg_valid2),
        .seg_ready  (seg_ready2),
        .byte_out   (byte_out2),
        .byte_valid (byte_valid2),
        .byte_ready (byte_ready2),
        .err_pulse  (err_pulse2),
        .err_code   (err_code2),
        .busy       (busy2)
`ifdef SEG7_ENC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks are entered right after a falling edge and return on one.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [6:0] p);
        seg_in    = p;
        seg_valid = 1'b1;
        @(negedge clk);
        seg_valid = 1'b0;
    endtask

    task automatic send2(input logic [6:0] p);
        seg_in2    = p;
        seg_valid2 = 1'b1;
        @(negedge clk);
        seg_valid2 = 1'b0;
    endtask

    // Hard stop in case anything stalls the flow.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        seg_in      = 7'd0;
        seg_valid   = 1'b0;
        byte_ready  = 1'b1;
        seg_in2     = 7'd0;
        seg_valid2  = 1'b0;
        byte_ready2 = 1'b1;
        step(2);

        // Reset state
        chk("rst_seg_ready", 16'(seg_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_byte_valid", 16'(byte_valid), 16'd0);
        chk("rst_byte_out", 16'(byte_out), 16'h00);
        chk("rst_err_pulse", 16'(err_pulse), 16'd0);
        chk("rst_err_code", 16'(err_code), 16'd0);
        rst_n = 1'b1;
        step(1);

        // 2,3 -> 0x23, byte_valid exactly one cycle
        send(7'b1101101);
        chk("t1_busy_half", 16'(busy), 16'd1);
        chk("t1_bv_half", 16'(byte_valid), 16'd0);
        send(7'b1111001);
        chk("t1_bv", 16'(byte_valid), 16'd1);
        chk("t1_byte", 16'(byte_out), 16'h23);
        chk("t1_seg_ready", 16'(seg_ready), 16'd0);
        step(1);
        chk("t1_bv_drop", 16'(byte_valid), 16'd0);
        chk("t1_idle", 16'(busy), 16'd0);
        chk("t1_seg_ready_back", 16'(seg_ready), 16'd1);

        // Full code table, pairs (0,1) (2,3) ... (E,F)
        for (int i = 0; i < 16; i += 2) begin
            send(pat[i]);
            send(pat[i+1]);
            chk("tbl_bv", 16'(byte_valid), 16'd1);
            chk("tbl_byte", 16'(byte_out), 16'(i * 16 + i + 1));
            step(1);
        end

        // B,F with downstream stalled for 5 cycles
        byte_ready = 1'b0;
        send(7'b1110111);
        send(7'b0111101);
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_byte", 16'(byte_out), 16'hBF);
            chk("t2_hold_bv", 16'(byte_valid), 16'd1);
            chk("t2_hold_seg_ready", 16'(seg_ready), 16'd0);
            step(1);
        end
        byte_ready = 1'b1;
        step(1);
        chk("t2_bv_drop", 16'(byte_valid), 16'd0);
        chk("t2_idle", 16'(busy), 16'd0);
        chk("t2_byte_kept", 16'(byte_out), 16'hBF);

        // Invalid in IDLE, then invalid in HALF, then completion
        send(7'b0000000);
        chk("t3_err1_pulse", 16'(err_pulse), 16'd1);
        chk("t3_err1_code", 16'(err_code), 16'b01);
        chk("t3_err1_idle", 16'(busy), 16'd0);
        send(7'b1111110);
        chk("t3_pulse_cleared", 16'(err_pulse), 16'd0);
        chk("t3_half", 16'(busy), 16'd1);
        send(7'b1010101);
        chk("t3_err2_pulse", 16'(err_pulse), 16'd1);
        chk("t3_err2_code", 16'(err_code), 16'b01);
        chk("t3_err2_half", 16'(busy), 16'd1);
        chk("t3_err2_no_byte", 16'(byte_valid), 16'd0);
        send(7'b1001110);
        chk("t3_bv", 16'(byte_valid), 16'd1);
        chk("t3_byte", 16'(byte_out), 16'h0A);
        chk("t3_no_err", 16'(err_pulse), 16'd0);
        step(1);

        // Timeout after 4 cycles in HALF
        send(7'b1101101);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("t4_still_half", 16'(busy), 16'd1);
            chk("t4_no_pulse", 16'(err_pulse), 16'd0);
        end
        step(1);
        chk("t4_to_pulse", 16'(err_pulse), 16'd1);
        chk("t4_to_code", 16'(err_code), 16'b10);
        chk("t4_to_idle", 16'(busy), 16'd0);
        step(1);
        chk("t4_to_pulse_end", 16'(err_pulse), 16'd0);
        chk("t4_code_held", 16'(err_code), 16'b10);

        // Second code arrives on the timeout cycle: accept wins
        send(7'b1101101);
        step(3);
        send(7'b1111001);
        chk("t4b_bv", 16'(byte_valid), 16'd1);
        chk("t4b_byte", 16'(byte_out), 16'h23);
        chk("t4b_no_pulse", 16'(err_pulse), 16'd0);
        step(1);

        // Async reset in HALF
        send(7'b1101101);
        #2 rst_n = 1'b0;
        #1;
        chk("t5a_busy", 16'(busy), 16'd0);
        chk("t5a_seg_ready", 16'(seg_ready), 16'd1);
        chk("t5a_byte", 16'(byte_out), 16'h00);
        chk("t5a_err_code", 16'(err_code), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset in FULL
        byte_ready = 1'b0;
        send(7'b1100111);
        send(7'b1111111);
        chk("t5b_full_byte", 16'(byte_out), 16'hC8);
        #2 rst_n = 1'b0;
        #1;
        chk("t5b_bv", 16'(byte_valid), 16'd0);
        chk("t5b_byte", 16'(byte_out), 16'h00);
        chk("t5b_seg_ready", 16'(seg_ready), 16'd1);
        chk("t5b_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        byte_ready = 1'b1;
        send(7'b1111111);
        send(7'b1111011);
        chk("t5c_bv", 16'(byte_valid), 16'd1);
        chk("t5c_byte", 16'(byte_out), 16'h89);
        step(1);

        // HI_FIRST=0, no timeout
        send2(7'b0110000);
        step(10);
        chk("lo_no_timeout_busy", 16'(busy2), 16'd1);
        chk("lo_no_timeout_err", 16'(err_code2), 16'd0);
        send2(7'b1111110);
        chk("lo_bv", 16'(byte_valid2), 16'd1);
        chk("lo_byte", 16'(byte_out2), 16'h01);
        step(1);

`ifdef SEG7_ENC_ERR_CNT_EN
        // Error counter saturation
        #2 rst_n = 1'b0;
        #1;
        chk("cnt_rst", 16'(err_cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) send(7'b1010101);
        chk("cnt_3", 16'(err_cnt), 16'd3);
        for (int k = 0; k < 257; k++) send(7'b1010101);
        chk("cnt_sat", 16'(err_cnt), 16'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
